// File: rtl/store_pkg.sv
// store_pkg -- shared definitions for the store packing unit.
//   SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD : req_size encodings (sb, sh, sw, reserved)
//   store_entry_t                   : packed buffer entry {addr, wdata, be}
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } store_entry_t;

endpackage

// File: rtl/store_pack_unit_if.sv
// store_pack_unit_if -- store request and data-memory write channels.
//   req_valid/req_ready/req_addr/req_data/req_size : pipeline store request
//   mem_valid/mem_ready/mem_addr/mem_wdata/mem_be  : packed write to data memory
// Modports:
//   master : pipeline/memory side (drives requests and mem_ready)
//   slave  : store_pack_unit side
interface store_pack_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_lane_pack.sv
// store_lane_pack -- combinational byte-lane packing of one store.
//   addr[1:0] : low address bits of the store
//   data      : register value being stored
//   size      : store size encoding (store_pkg SZ_*)
//   wdata     : lane-replicated write data
//   be        : byte enables, bit i covers wdata[8i+7:8i]
//   bad       : store is misaligned or reserved (only with STORE_MISALIGN_TRAP_EN)
// Build option: STORE_MISALIGN_TRAP_EN flags misaligned sh/sw and reserved
// sizes; otherwise the offending address bits are ignored and reserved = word.
module store_lane_pack
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        bad
);

  always_comb begin
    wdata = data;
    be    = 4'b1111;
    bad   = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr;
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        be    = addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
        bad   = addr[0];
`endif
      end
      SZ_WORD: begin
`ifdef STORE_MISALIGN_TRAP_EN
        bad = (addr != 2'b00);
`endif
      end
      default: begin
        // Reserved size: dropped in the trap build, otherwise a plain word.
`ifdef STORE_MISALIGN_TRAP_EN
        bad = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/store_pack_unit.sv
// store_pack_unit -- packs pipeline stores and buffers them for data memory.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : store_pack_unit_if.slave (request in, packed write out)
//   misalign : one-cycle pulse for a dropped misaligned/reserved store
//   busy     : buffer holds at least one entry
// Parameter DEPTH (power of two, >= 2) sets the number of buffered entries.
// Build option: STORE_MISALIGN_TRAP_EN enables dropping and flagging bad stores.
module store_pack_unit
  import store_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  store_pack_unit_if.slave   bus,
  output logic               misalign,
  output logic               busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  store_entry_t fifo_mem [DEPTH];
  store_entry_t head;

  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          ready_en_reg;

  logic [31:0] pk_wdata;
  logic [3:0]  pk_be;
  logic        pk_bad;
  logic        accept, push, pop;

  store_lane_pack u_pack (
    .addr  (bus.req_addr[1:0]),
    .data  (bus.req_data),
    .size  (bus.req_size),
    .wdata (pk_wdata),
    .be    (pk_be),
    .bad   (pk_bad)
  );

  // ready_en_reg holds req_ready low during reset and until the first edge
  // after release.
  assign bus.req_ready = ready_en_reg && (count_reg < DEPTH_C);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = accept && !pk_bad;
  assign pop           = bus.mem_valid && bus.mem_ready;

  assign bus.mem_valid = (count_reg != '0);
  assign busy          = bus.mem_valid;

  assign head          = fifo_mem[rd_ptr_reg];
  assign bus.mem_addr  = head.addr;
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = head.be;

  // Entry storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= '{addr:  {bus.req_addr[31:2], 2'b00},
                                wdata: pk_wdata,
                                be:    pk_be};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic misalign_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_reg <= 1'b0;
    else     misalign_reg <= accept && pk_bad;
  end

  assign misalign = misalign_reg;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_store_pack_unit.sv
// tb_store_pack_unit -- randomized and directed bench for store_pack_unit.
// Honours STORE_MISALIGN_TRAP_EN to match the build under test.
module tb_store_pack_unit;

  localparam int DEPTH = 2;
`ifdef STORE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic misalign, busy;

  store_pack_unit_if bus ();

  store_pack_unit #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .misalign (misalign),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: queue of {addr, wdata, be} still owed to memory.
  logic [67:0] q[$];
  bit          rst_ok  = 1'b0;
  bit          exp_mis = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Packing rules computed arithmetically from the store semantics.
  function automatic void model_pack(input logic [31:0] a, input logic [31:0] d,
                                     input logic [1:0] sz, output logic [31:0] w,
                                     output logic [3:0] be, output bit bad);
    int lane = int'(a[1:0]);
    bad = 1'b0;
    if (sz == 2'd0) begin
      w  = {24'd0, d[7:0]} * 32'h01010101;
      be = 4'(1 << lane);
    end else if (sz == 2'd1) begin
      w   = {16'd0, d[15:0]} * 32'h00010001;
      be  = (lane >= 2) ? 4'hC : 4'h3;
      bad = TRAP && (lane % 2 == 1);
    end else begin
      w   = d;
      be  = 4'hF;
      bad = TRAP && (sz == 2'd3 || lane != 0);
    end
  endfunction

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit mr);
    bit exp_ready;
    logic [31:0] w;
    logic [3:0]  be;
    bit bad;
    exp_ready = rst_ok && (q.size() < DEPTH);
    check("req_ready", bus.req_ready, exp_ready);
    check("mem_valid", bus.mem_valid, q.size() != 0);
    check("busy", busy, q.size() != 0);
    check("misalign", misalign, exp_mis);
    if (q.size() != 0) begin
      check("mem_addr", bus.mem_addr, q[0][67:36]);
      check("mem_wdata", bus.mem_wdata, q[0][35:4]);
      check("mem_be", bus.mem_be, {28'd0, q[0][3:0]});
    end
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.req_size  = sz;
    bus.mem_ready = mr;
    @(posedge clk);
    exp_mis = 1'b0;
    if (q.size() != 0 && mr) void'(q.pop_front());
    if (v && exp_ready) begin
      model_pack(a, d, sz, w, be, bad);
      if (bad) begin
        exp_mis = 1'b1;
        $display("store addr=%h data=%h size=%0d dropped (misaligned)", a, d, sz);
      end else begin
        q.push_back({a[31:2], 2'b00, w, be});
        $display("store addr=%h data=%h size=%0d -> wdata=%h be=%b", a, d, sz, w, be);
      end
    end
    rst_ok = 1'b1;
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle while entries are buffered and a handshake is live.
  task automatic mid_reset();
    bus.req_valid = 1'b1;
    bus.mem_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_mem_valid", bus.mem_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_misalign", misalign, 1'b0);
    q.delete();
    rst_ok  = 1'b0;
    exp_mis = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("reset pulse applied");
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.req_size  = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1'b0);
    check("reset_mem_valid", bus.mem_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_misalign", misalign, 1'b0);
    rst = 1'b0;
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // sb to 0x1003
    step(1'b1, 32'h0000_1003, 32'h0000_00A5, 2'd0, 1'b1);
    check("sb_addr", bus.mem_addr, 32'h0000_1000);
    check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
    check("sb_be", {28'd0, bus.mem_be}, 32'h8);
    // sh to 0x2002, sw to 0x2004
    step(1'b1, 32'h0000_2002, 32'h1234_BEEF, 2'd1, 1'b1);
    check("sh_wdata", bus.mem_wdata, 32'hBEEF_BEEF);
    check("sh_be", {28'd0, bus.mem_be}, 32'hC);
    step(1'b1, 32'h0000_2004, 32'h1234_BEEF, 2'd2, 1'b1);
    check("sw_wdata", bus.mem_wdata, 32'h1234_BEEF);
    check("sw_be", {28'd0, bus.mem_be}, 32'hF);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Fill with memory stalled, third store waits, drain in order.
    step(1'b1, 32'h0000_4000, 32'h1111_1111, 2'd2, 1'b0);
    step(1'b1, 32'h0000_4004, 32'h2222_2222, 2'd2, 1'b0);
    check("full_ready", bus.req_ready, 1'b0);
    step(1'b1, 32'h0000_4008, 32'h3333_3333, 2'd2, 1'b0);
    step(1'b1, 32'h0000_4008, 32'h3333_3333, 2'd2, 1'b1);
    step(1'b1, 32'h0000_4008, 32'h3333_3333, 2'd2, 1'b1);
    repeat (3) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // sw to 0x3002
    step(1'b1, 32'h0000_3002, 32'hCAFE_F00D, 2'd2, 1'b1);
`ifdef STORE_MISALIGN_TRAP_EN
    check("trap_misalign", misalign, 1'b1);
    check("trap_mem_valid", bus.mem_valid, 1'b0);
`else
    check("notrap_addr", bus.mem_addr, 32'h0000_3000);
    check("notrap_be", {28'd0, bus.mem_be}, 32'hF);
    check("notrap_misalign", misalign, 1'b0);
`endif
    repeat (2) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Two entries buffered, then reset mid-handshake.
    step(1'b1, 32'h0000_5000, 32'hAAAA_0001, 2'd2, 1'b0);
    step(1'b1, 32'h0000_5004, 32'hAAAA_0002, 2'd2, 1'b0);
    mid_reset();
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      step($urandom_range(0, 3) != 0,
           {20'd0, 12'($urandom)},
           $urandom,
           2'($urandom_range(0, 3)),
           $urandom_range(0, 2) != 0);
    end
    repeat (4) step(1'b0, 32'h0, 32'h0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
